// File: rtl/datapath_towerplacer_if.sv
// datapath_towerplacer_if: strobe, path-ROM probe and VGA pixel bundle between control FSM and datapath
interface datapath_towerplacer_if;
    logic       top_left;
    logic       draw_square;
    logic       draw_tower;
    logic       move_down;
    logic       move_right;
    logic       move_down_wait;
    logic       move_right_wait;
    logic       erase_square_right;
    logic       erase_square_down;
    logic       erase_square_tower;
    logic       cell_is_path;
    logic [2:0] probe_row;
    logic [3:0] probe_col;
    logic       valid;
    logic       square_done;
    logic       erase_square_done;
    logic       tower_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [6:0] towers_placed;

    modport master (
        output top_left, draw_square, draw_tower, move_down, move_right,
               move_down_wait, move_right_wait, erase_square_right,
               erase_square_down, erase_square_tower, cell_is_path,
        input  probe_row, probe_col, valid, square_done, erase_square_done,
               tower_done, x, y, colour, plot, towers_placed
    );

    modport slave (
        input  top_left, draw_square, draw_tower, move_down, move_right,
               move_down_wait, move_right_wait, erase_square_right,
               erase_square_down, erase_square_tower, cell_is_path,
        output probe_row, probe_col, valid, square_done, erase_square_done,
               tower_done, x, y, colour, plot, towers_placed
    );
endinterface

// File: rtl/datapath_towerplacer.sv
// datapath_towerplacer: cursor position, tower occupancy map and VGA pixel sweeps for tower placement
module datapath_towerplacer #(
    parameter int         GRID_COLS     = 10,
    parameter int         GRID_ROWS     = 7,
    parameter int         CELL_SIZE     = 16,
    parameter logic [2:0] CURSOR_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR     = 3'b010,
    parameter logic [2:0] TOWER_COLOUR  = 3'b001
) (
    input logic                  clk,
    input logic                  resetn,
    datapath_towerplacer_if.slave bus
);
    localparam int LOG = $clog2(CELL_SIZE);
    localparam int PW  = 2 * LOG;
    localparam int NC  = GRID_ROWS * GRID_COLS;
    localparam int IW  = $clog2(NC);

    typedef enum logic [2:0] {OP_IDLE, OP_TOP, OP_TOWER, OP_ERASE, OP_SQUARE, OP_DOWN, OP_RIGHT, OP_WAIT} op_t;

    logic [2:0]    r_row;
    logic [3:0]    r_col;
    logic [PW-1:0] r_p;
    logic [3:0]    r_step;
    logic [NC-1:0] r_occ;
    logic [6:0]    r_towers;
    logic [7:0]    r_x;
    logic [6:0]    r_y;
    logic [2:0]    r_colour;
    logic          r_plot;

    op_t           w_op;
    logic [2:0]    w_row_nx;
    logic [3:0]    w_col_nx;
    logic [3:0]    w_step_nx;
    logic [2:0]    w_prow;
    logic [3:0]    w_pcol;
    logic [IW-1:0] w_cidx;
    logic [IW-1:0] w_pidx;
    logic [LOG-1:0] w_ox;
    logic [LOG-1:0] w_oy;
    logic          w_last;
    logic          w_border;
    logic          w_sweep;
    logic          w_force;
    logic          w_cell_occ;
    logic          w_blocked;

    // Strobe priority decode, probe cell, sweep geometry and escape-hatch valid forcing
    always_comb begin
        w_op = bus.top_left ? OP_TOP :
               bus.draw_tower ? OP_TOWER :
               (bus.erase_square_right | bus.erase_square_down | bus.erase_square_tower) ? OP_ERASE :
               bus.draw_square ? OP_SQUARE :
               bus.move_down ? OP_DOWN :
               bus.move_right ? OP_RIGHT :
               (bus.move_down_wait | bus.move_right_wait) ? OP_WAIT : OP_IDLE;
        w_row_nx   = (r_row == 3'(GRID_ROWS - 1)) ? 3'd0 : r_row + 3'd1;
        w_col_nx   = (r_col == 4'(GRID_COLS - 1)) ? 4'd0 : r_col + 4'd1;
        w_step_nx  = r_step + 4'd1;
        w_prow     = (w_op == OP_DOWN) ? w_row_nx : r_row;
        w_pcol     = (w_op == OP_RIGHT) ? w_col_nx : r_col;
        w_cidx     = IW'(r_row) * IW'(GRID_COLS) + IW'(r_col);
        w_pidx     = IW'(w_prow) * IW'(GRID_COLS) + IW'(w_pcol);
        w_ox       = r_p[LOG-1:0];
        w_oy       = r_p[PW-1:LOG];
        w_last     = &r_p;
        w_border   = (w_ox == '0) || (&w_ox) || (w_oy == '0) || (&w_oy);
        w_sweep    = (w_op == OP_TOWER) || (w_op == OP_ERASE) || (w_op == OP_SQUARE);
        w_force    = ((w_op == OP_DOWN) && (w_step_nx == 4'(GRID_ROWS - 1))) ||
                     ((w_op == OP_RIGHT) && (w_step_nx == 4'(GRID_COLS - 1)));
        w_cell_occ = r_occ[w_cidx];
        w_blocked  = w_cell_occ || bus.cell_is_path;
    end

    assign bus.probe_row         = w_prow;
    assign bus.probe_col         = w_pcol;
    assign bus.valid             = w_force || (!bus.cell_is_path && !r_occ[w_pidx]);
    assign bus.square_done       = (w_op == OP_SQUARE) && w_last;
    assign bus.erase_square_done = (w_op == OP_ERASE) && w_last;
    assign bus.tower_done        = (w_op == OP_TOWER) && w_last;
    assign bus.x                 = r_x;
    assign bus.y                 = r_y;
    assign bus.colour            = r_colour;
    assign bus.plot              = r_plot;
    assign bus.towers_placed     = r_towers;

    // Cursor, counters, occupancy commit and registered pixel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row    <= '0;
            r_col    <= '0;
            r_p      <= '0;
            r_step   <= '0;
            r_occ    <= '0;
            r_towers <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_p    <= (w_sweep && !w_last) ? r_p + PW'(1) : (w_op == OP_WAIT) ? r_p : '0;
            r_step <= (w_op == OP_DOWN || w_op == OP_RIGHT) ? w_step_nx : (w_op == OP_WAIT) ? r_step : '0;
            r_row  <= (w_op == OP_TOP) ? 3'd0 : (w_op == OP_DOWN) ? w_row_nx : r_row;
            r_col  <= (w_op == OP_TOP) ? 4'd0 : (w_op == OP_RIGHT) ? w_col_nx : r_col;
            r_plot <= w_sweep && ((w_op == OP_TOWER) ? !w_blocked : w_border);
            if (w_sweep) begin
                r_x      <= 8'({r_col, w_ox});
                r_y      <= 7'({r_row, w_oy});
                r_colour <= (w_op == OP_SQUARE) ? CURSOR_COLOUR :
                            (w_op == OP_ERASE && !w_cell_occ) ? BG_COLOUR : TOWER_COLOUR;
            end
            if (w_op == OP_TOWER && w_last && !w_blocked) begin
                r_occ[w_cidx] <= 1'b1;
                r_towers      <= (&r_towers) ? r_towers : r_towers + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_datapath_towerplacer.sv
// tb_datapath_towerplacer: directed checks of cursor moves, valid forcing, pixel sweeps and tower placement
module tb_datapath_towerplacer;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic [69:0] rom;

    always #5 clk = ~clk;

    datapath_towerplacer_if bus();

    datapath_towerplacer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    assign bus.cell_is_path = (int'(bus.probe_row) * 10 + int'(bus.probe_col) < 70) ?
                              rom[int'(bus.probe_row) * 10 + int'(bus.probe_col)] : 1'b0;

    int total = 0;
    int bad = 0;
    int n_plot = 0;
    int n_badc = 0;
    int n_badxy = 0;
    int n_badb = 0;
    logic [2:0] m_colour = 3'd0;
    int m_xlo = 0;
    int m_ylo = 0;
    bit m_border = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pixel monitor: registered outputs are stable at the falling edge
    always @(negedge clk) begin
        if (bus.plot === 1'b1) begin
            n_plot++;
            if (bus.colour !== m_colour) n_badc++;
            if (int'(bus.x) < m_xlo || int'(bus.x) > m_xlo + 15 || int'(bus.y) < m_ylo || int'(bus.y) > m_ylo + 15) n_badxy++;
            if (m_border && !(int'(bus.x) == m_xlo || int'(bus.x) == m_xlo + 15 ||
                              int'(bus.y) == m_ylo || int'(bus.y) == m_ylo + 15)) n_badb++;
        end
    end

    task automatic clr();
        bus.top_left = 0; bus.draw_square = 0; bus.draw_tower = 0;
        bus.move_down = 0; bus.move_right = 0; bus.move_down_wait = 0; bus.move_right_wait = 0;
        bus.erase_square_right = 0; bus.erase_square_down = 0; bus.erase_square_tower = 0;
    endtask

    task automatic set_op(input int op, input logic v);
        case (op)
            0: bus.draw_square = v;
            1: bus.draw_tower = v;
            2: bus.erase_square_right = v;
            3: bus.erase_square_down = v;
            4: bus.erase_square_tower = v;
            5: bus.move_down = v;
            6: bus.move_right = v;
            default: bus.top_left = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic goto_cell(input int r, input int c);
        @(negedge clk); clr(); bus.top_left = 1;
        idle(1);
        repeat (r) begin @(negedge clk); bus.move_down = 1; end
        idle(1);
        repeat (c) begin @(negedge clk); bus.move_right = 1; end
        idle(1);
        #1;
    endtask

    task automatic sweep(input int op, input int r, input int c, input int col, input bit border,
                         output int plots, output int dones, output int done_last);
        int p0;
        logic d;
        m_colour = 3'(col); m_xlo = c * 16; m_ylo = r * 16; m_border = border;
        p0 = n_plot; dones = 0; done_last = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            set_op(op, 1'b1);
            #1;
            d = (op == 0) ? bus.square_done : (op == 1) ? bus.tower_done : bus.erase_square_done;
            if (d) dones++;
            if (i == 255 && d) done_last = 1;
        end
        @(negedge clk);
        set_op(op, 1'b0);
        idle(2);
        plots = n_plot - p0;
    endtask

    int plots, dones, dlast;
    int v1, v2, v3, nlow, v9, pc9, v10;

    initial begin
        clr();
        rom = '0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_towers", int'(bus.towers_placed), 0);
        chk("rst_probe", int'({bus.probe_row, bus.probe_col}), 0);
        chk("rst_valid", int'(bus.valid), 1);
        chk("rst_done", int'({bus.square_done, bus.erase_square_done, bus.tower_done}), 0);
        @(negedge clk);
        resetn = 1'b1;

        // cursor outline at (0,0)
        goto_cell(0, 0);
        sweep(0, 0, 0, 6, 1'b1, plots, dones, dlast);
        chk("sq_plots", plots, 60);
        chk("sq_done_cnt", dones, 1);
        chk("sq_done_last", dlast, 1);
        chk("sq_colour", n_badc, 0);
        chk("sq_xy", n_badxy, 0);
        chk("sq_border", n_badb, 0);

        // move_down past path rows 1-2 of column 0
        rom = '0; rom[10] = 1; rom[20] = 1;
        goto_cell(0, 0);
        @(negedge clk); bus.move_down = 1; #1; v1 = int'(bus.valid);
        @(negedge clk); #1; v2 = int'(bus.valid);
        @(negedge clk); #1; v3 = int'(bus.valid);
        idle(1); #1;
        chk("dn_v1", v1, 0);
        chk("dn_v2", v2, 0);
        chk("dn_v3", v3, 1);
        chk("dn_row", int'(bus.probe_row), 3);

        // move_right past all-path column 3
        rom = '0;
        for (int r = 0; r < 7; r++) rom[r * 10 + 3] = 1;
        goto_cell(0, 2);
        @(negedge clk); bus.move_right = 1; #1; v1 = int'(bus.valid);
        @(negedge clk); #1; v2 = int'(bus.valid);
        idle(1); #1;
        chk("rt_v1", v1, 0);
        chk("rt_v2", v2, 1);
        chk("rt_col", int'(bus.probe_col), 4);

        // row 0 all path except column 0: forced valid then wrap
        rom = '0;
        for (int c = 1; c < 10; c++) rom[c] = 1;
        goto_cell(0, 0);
        nlow = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); bus.move_right = 1; #1;
            if (k <= 8 && !bus.valid) nlow++;
            if (k == 9) begin v9 = int'(bus.valid); pc9 = int'(bus.probe_col); end
            if (k == 10) v10 = int'(bus.valid);
        end
        idle(1); #1;
        chk("wr_low", nlow, 8);
        chk("wr_v9", v9, 1);
        chk("wr_pcol9", pc9, 9);
        chk("wr_v10", v10, 1);
        chk("wr_col", int'(bus.probe_col), 0);

        // tower at (2,4)
        rom = '0;
        goto_cell(2, 4);
        chk("tw_probe", int'(bus.probe_row) * 16 + int'(bus.probe_col), 2 * 16 + 4);
        chk("tw_valid_pre", int'(bus.valid), 1);
        sweep(1, 2, 4, 1, 1'b0, plots, dones, dlast);
        #1;
        chk("tw_plots", plots, 256);
        chk("tw_done_cnt", dones, 1);
        chk("tw_done_last", dlast, 1);
        chk("tw_count", int'(bus.towers_placed), 1);
        chk("tw_valid_post", int'(bus.valid), 0);
        chk("tw_colour", n_badc, 0);
        chk("tw_xy", n_badxy, 0);
        sweep(1, 2, 4, 1, 1'b0, plots, dones, dlast);
        #1;
        chk("tw2_plots", plots, 0);
        chk("tw2_done_cnt", dones, 1);
        chk("tw2_count", int'(bus.towers_placed), 1);

        // erase over occupied and free cells
        sweep(3, 2, 4, 1, 1'b1, plots, dones, dlast);
        chk("er_occ_plots", plots, 60);
        chk("er_occ_done", dlast, 1);
        chk("er_occ_colour", n_badc, 0);
        @(negedge clk); bus.move_right = 1;
        idle(1);
        sweep(2, 2, 5, 2, 1'b1, plots, dones, dlast);
        chk("er_bg_plots", plots, 60);
        chk("er_bg_done", dlast, 1);
        chk("er_bg_colour", n_badc, 0);
        chk("er_border", n_badb, 0);

        // reset in the middle of a tower sweep at (2,5)
        m_colour = 3'b001; m_xlo = 80; m_ylo = 32; m_border = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk); bus.draw_tower = 1;
        end
        #1;
        chk("mid_plot_pre", int'(bus.plot), 1);
        resetn = 1'b0;
        #1;
        chk("mid_plot", int'(bus.plot), 0);
        chk("mid_towers", int'(bus.towers_placed), 0);
        chk("mid_x", int'(bus.x), 0);
        @(negedge clk);
        clr();
        resetn = 1'b1;
        goto_cell(2, 4);
        chk("post_valid_24", int'(bus.valid), 1);
        goto_cell(2, 5);
        chk("post_valid_25", int'(bus.valid), 1);
        chk("post_towers", int'(bus.towers_placed), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
